// File: rtl/blink_pkg.sv
// Shared types and helpers for the LED blink controller.
// Holds the FSM state type and the timer width rule.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    // Width that holds max(a,b)-1, never below one bit.
    function automatic int tmr_width(int a, int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cyc_timer_sv.sv
// Loadable down-counter that stops at zero.
// o_done is high whenever the count is zero.
module cyc_timer_sv #(
    parameter int W = 1
) (
    input  logic         i_sysclk_40,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_sysclk_40 or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign o_done = (cnt == '0);

endmodule

// File: rtl/led_blink_sv.sv
// Queued LED blinker: each accepted i_pulse yields one
// ON_CNT-cycle blink followed by an OFF_CNT-cycle gap.
module led_blink_sv #(
    parameter int   ON_CNT          = 8000000,
    parameter int   OFF_CNT         = 8000000,
    parameter int   MAX_PEND        = 7,
    parameter logic ACTIVE_HIGH_LED = 1'b1
) (
    input  logic                              i_sysclk_40,
    input  logic                              i_rst,
    input  logic                              i_pulse,
    output logic                              o_led,
    output logic                              o_busy,
    output logic [$clog2(MAX_PEND+1)-1:0]     o_pend,
    output logic                              o_drop
);

    import blink_pkg::*;

    localparam int TW = tmr_width(ON_CNT, OFF_CNT);
    localparam int PW = $clog2(MAX_PEND + 1);
    localparam logic [TW-1:0] ON_LD  = TW'(ON_CNT - 1);
    localparam logic [TW-1:0] OFF_LD = TW'(OFF_CNT - 1);
    localparam logic [PW-1:0] PMAX   = PW'(MAX_PEND);

    blink_state_t  state;
    blink_state_t  state_nxt;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    logic          enter_on;
    logic          full;
    logic [PW-1:0] pend_nxt;
    logic          drop_nxt;

    cyc_timer_sv #(.W(TW)) u_tmr (
        .i_sysclk_40 (i_sysclk_40),
        .i_rst       (i_rst),
        .i_load      (tmr_load),
        .i_val       (tmr_val),
        .o_done      (tmr_done)
    );

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        unique case (state)
            IDLE: begin
                if (o_pend != '0) begin
                    state_nxt = ON;
                    tmr_load  = 1'b1;
                    tmr_val   = ON_LD;
                end
            end
            ON: begin
                if (tmr_done) begin
                    state_nxt = OFF;
                    tmr_load  = 1'b1;
                    tmr_val   = OFF_LD;
                end
            end
            OFF: begin
                if (tmr_done) begin
                    if (o_pend != '0) begin
                        state_nxt = ON;
                        tmr_load  = 1'b1;
                        tmr_val   = ON_LD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A request is consumed on the edge that starts its blink.
    assign enter_on = (state_nxt == ON) && (state != ON);
    assign full     = (o_pend == PMAX);

    always_comb begin
        pend_nxt = o_pend;
        drop_nxt = 1'b0;
        unique case (1'b1)
            (i_pulse && !enter_on && full):  drop_nxt = 1'b1;
            (i_pulse && !enter_on && !full): pend_nxt = o_pend + PW'(1);
            (!i_pulse && enter_on):          pend_nxt = o_pend - PW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge i_sysclk_40 or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            o_pend <= '0;
            o_led  <= ~ACTIVE_HIGH_LED;
            o_busy <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_pend <= pend_nxt;
            o_led  <= (state_nxt == ON) ? ACTIVE_HIGH_LED
                                        : ~ACTIVE_HIGH_LED;
            o_busy <= (state_nxt != IDLE);
            o_drop <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_led_blink_sv.sv
// Bench for led_blink_sv: directed scenarios plus random
// pulses and resets against a blink-schedule reference model.
module tb_led_blink_sv;

    localparam int ON  = 4;
    localparam int OFF = 3;
    localparam int MP  = 2;
    localparam int P   = ON + OFF;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       pulse = 1'b0;
    logic       led, busy, drop;
    logic       led_n, busy_n, drop_n;
    logic [1:0] pend, pend_n;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int starts[$];
    int arrs[$];
    int drops[$];
    int last_s = -1000;

    logic       led_h  [0:127];
    logic       ledn_h [0:127];
    logic       busy_h [0:127];
    logic       drop_h [0:127];
    logic [1:0] pend_h [0:127];

    led_blink_sv #(
        .ON_CNT(ON), .OFF_CNT(OFF), .MAX_PEND(MP),
        .ACTIVE_HIGH_LED(1'b1)
    ) dut (
        .i_sysclk_40 (clk),
        .i_rst       (rst),
        .i_pulse     (pulse),
        .o_led       (led),
        .o_busy      (busy),
        .o_pend      (pend),
        .o_drop      (drop)
    );

    led_blink_sv #(
        .ON_CNT(ON), .OFF_CNT(OFF), .MAX_PEND(MP),
        .ACTIVE_HIGH_LED(1'b0)
    ) dut_n (
        .i_sysclk_40 (clk),
        .i_rst       (rst),
        .i_pulse     (pulse),
        .o_led       (led_n),
        .o_busy      (busy_n),
        .o_pend      (pend_n),
        .o_drop      (drop_n)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d",
                     tag, cyc, got, exp);
        end
    endtask

    // Reference: each accepted request owns a blink start time.
    function automatic int m_pend(int c);
        int n = 0;
        foreach (starts[i])
            if (arrs[i] < c && starts[i] > c) n++;
        return n;
    endfunction

    function automatic bit m_led(int c);
        foreach (starts[i])
            if (c >= starts[i] && c < starts[i] + ON) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy(int c);
        foreach (starts[i])
            if (c >= starts[i] && c < starts[i] + P) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_drop(int c);
        foreach (drops[i])
            if (drops[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_start_at(int c);
        foreach (starts[i])
            if (starts[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        starts.delete();
        arrs.delete();
        drops.delete();
        last_s = -1000;
    endtask

    task automatic model_accept(int c);
        int s;
        if (m_pend(c) == MP && !m_start_at(c + 1)) begin
            drops.push_back(c + 1);
        end else begin
            s = (c + 2 > last_s + P) ? c + 2 : last_s + P;
            starts.push_back(s);
            arrs.push_back(c);
            last_s = s;
        end
    endtask

    task automatic check_cycle();
        bit el, eb, ed;
        int ep;
        if (rst) begin
            el = 0; eb = 0; ed = 0; ep = 0;
        end else begin
            el = m_led(cyc);
            eb = m_busy(cyc);
            ed = m_drop(cyc);
            ep = m_pend(cyc);
        end
        chk("led",    32'(led),    32'(el));
        chk("led_n",  32'(led_n),  32'(!el));
        chk("busy",   32'(busy),   32'(eb));
        chk("busy_n", 32'(busy_n), 32'(eb));
        chk("pend",   32'(pend),   ep);
        chk("pend_n", 32'(pend_n), ep);
        chk("drop",   32'(drop),   32'(ed));
        chk("drop_n", 32'(drop_n), 32'(ed));
        if (cyc >= 0 && cyc < 128) begin
            led_h[cyc]  = led;
            ledn_h[cyc] = led_n;
            busy_h[cyc] = busy;
            drop_h[cyc] = drop;
            pend_h[cyc] = pend;
        end
    endtask

    task automatic step(bit p);
        @(posedge clk);
        #1;
        cyc++;
        pulse = p && !rst;
        @(negedge clk);
        check_cycle();
        if (pulse) model_accept(cyc);
    endtask

    // Called mid-cycle; asserts reset away from any clock edge.
    task automatic reset_seq(int n);
        #2;
        rst   = 1'b1;
        pulse = 1'b0;
        #1;
        model_clear();
        check_cycle();
        repeat (n) step(1'b0);
        #2;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_scen(int n, logic [63:0] pm);
        for (int c = 1; c <= n; c++) step(pm[c]);
    endtask

    int nb;

    initial begin
        @(negedge clk);
        check_cycle();
        reset_seq(2);

        run_scen(25, 64'd1 << 10);
        chk("s1_led11",  32'(led_h[11]),  0);
        chk("s1_led12",  32'(led_h[12]),  1);
        chk("s1_led15",  32'(led_h[15]),  1);
        chk("s1_led16",  32'(led_h[16]),  0);
        chk("s1_busy18", 32'(busy_h[18]), 1);
        chk("s1_busy19", 32'(busy_h[19]), 0);
        chk("s1_ledn11", 32'(ledn_h[11]), 1);
        chk("s1_ledn12", 32'(ledn_h[12]), 0);
        chk("s1_ledn15", 32'(ledn_h[15]), 0);

        reset_seq(2);
        run_scen(36, (64'd1 << 10) | (64'd1 << 11) | (64'd1 << 12));
        chk("s2_led19",  32'(led_h[19]),  1);
        chk("s2_led26",  32'(led_h[26]),  1);
        chk("s2_led30",  32'(led_h[30]),  0);
        chk("s2_busy32", 32'(busy_h[32]), 1);
        chk("s2_busy33", 32'(busy_h[33]), 0);

        reset_seq(2);
        run_scen(36, (64'd1 << 10) | (64'd1 << 13) |
                     (64'd1 << 14) | (64'd1 << 15));
        chk("s3_pend15", 32'(pend_h[15]), 2);
        chk("s3_drop16", 32'(drop_h[16]), 1);
        chk("s3_drop17", 32'(drop_h[17]), 0);
        nb = 0;
        for (int c = 2; c <= 36; c++)
            if (led_h[c] && !led_h[c-1]) nb++;
        chk("s3_blinks", nb, 3);

        reset_seq(2);
        run_scen(28, (64'd1 << 10) | (64'd1 << 18));
        chk("s4_busy19", 32'(busy_h[19]), 0);
        chk("s4_led19",  32'(led_h[19]),  0);
        chk("s4_led20",  32'(led_h[20]),  1);
        chk("s4_led23",  32'(led_h[23]),  1);
        chk("s4_led24",  32'(led_h[24]),  0);

        reset_seq(2);
        run_scen(13, 64'd1 << 10);
        chk("s5_led13", 32'(led_h[13]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("s5_async_led",  32'(led),  0);
        chk("s5_async_busy", 32'(busy), 0);
        chk("s5_async_ledn", 32'(led_n), 1);
        #1;
        reset_seq(3);
        run_scen(40, 64'd1 << 30);
        nb = 0;
        for (int c = 1; c <= 31; c++)
            if (led_h[c]) nb++;
        chk("s5_quiet", nb, 0);
        chk("s5_led32", 32'(led_h[32]), 1);

        reset_seq(2);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0)
                reset_seq($urandom_range(1, 3));
            else
                step($urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
